// File: rtl/melody_pkg.sv
// Shared state type, ROM entry layout and pitch table for the melody sequencer.
package melody_pkg;

    localparam int IDX_W     = 4;
    localparam int PERIOD_W  = 16;

    localparam int END_BIT   = 7;
    localparam int DUR_MSB   = 6;
    localparam int DUR_LSB   = 4;
    localparam int PITCH_MSB = 3;
    localparam int PITCH_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        NOTE,
        GAP
    } melodyState_t;

    // Half-periods in 50 MHz clock cycles, C5..C7 major scale (pitch codes 1..15)
    localparam logic [PERIOD_W-1:0] PITCH_TABLE [15] = '{
        16'd47778, 16'd42566, 16'd37922, 16'd35793, 16'd31888,
        16'd28409, 16'd25310, 16'd23889, 16'd21283, 16'd18961,
        16'd17897, 16'd15944, 16'd14205, 16'd12655, 16'd11945
    };

    function automatic logic [PERIOD_W-1:0] pitchHalfPeriod(input logic [3:0] pitch);
        logic [PERIOD_W-1:0] result;
        result = '0;
        if (pitch != 4'd0) begin
            result = PITCH_TABLE[pitch - 4'd1];
        end
        return result;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational 16x8 melody ROM: {END, DUR[2:0], PITCH[3:0]} per entry.
module melody_rom
    import melody_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       data
);

    always_comb begin
        data = 8'h00;
        case (idx)
            4'd0:    data = 8'h13;
            4'd1:    data = 8'h20;
            4'd2:    data = 8'h85;
            4'd3:    data = 8'h12;
            4'd4:    data = 8'h11;
            4'd5:    data = 8'h02;
            4'd6:    data = 8'h03;
            4'd7:    data = 8'h35;
            4'd8:    data = 8'h15;
            4'd9:    data = 8'h16;
            4'd10:   data = 8'h18;
            4'd11:   data = 8'h10;
            4'd12:   data = 8'h08;
            4'd13:   data = 8'h07;
            4'd14:   data = 8'h15;
            default: data = 8'hB8;
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Plays the ROM melody as tone half-periods for a square-wave generator.
// Define MELODY_SEQUENCER_LOOP_EN to restart from entry 0 after the last note.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int UNIT_TICKS = 1_500_000,
    parameter int GAP_TICKS  = 300_000,
    parameter int LAST_IDX   = 15
)(
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iPLAY,
    input  logic                iSTOP,
    output logic [PERIOD_W-1:0] oHALF_PERIOD,
    output logic                oNOTE_ON,
    output logic                oBUSY,
    output logic [IDX_W-1:0]    oNOTE_IDX,
    output logic                oDONE
);

    localparam int NOTE_MAX = 8 * UNIT_TICKS;
    localparam int CNT_MAX  = (NOTE_MAX > GAP_TICKS) ? NOTE_MAX : GAP_TICKS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    melodyState_t         state, stateNext;
    logic [CNT_W-1:0]     cnt, cntNext;
    logic                 endFlag, endFlagNext;
    logic [PERIOD_W-1:0]  halfNext;
    logic                 noteOnNext, busyNext, doneNext;
    logic [IDX_W-1:0]     idxNext;
    logic [7:0]           romData;
    logic [3:0]           romPitch;

    melody_rom uRom (
        .idx  (oNOTE_IDX),
        .data (romData)
    );

    assign romPitch = romData[PITCH_MSB:PITCH_LSB];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            cnt          <= '0;
            endFlag      <= 1'b0;
            oHALF_PERIOD <= '0;
            oNOTE_ON     <= 1'b0;
            oBUSY        <= 1'b0;
            oNOTE_IDX    <= '0;
            oDONE        <= 1'b0;
        end else begin
            state        <= stateNext;
            cnt          <= cntNext;
            endFlag      <= endFlagNext;
            oHALF_PERIOD <= halfNext;
            oNOTE_ON     <= noteOnNext;
            oBUSY        <= busyNext;
            oNOTE_IDX    <= idxNext;
            oDONE        <= doneNext;
        end
    end

    // Next-state and next-output logic; every output is registered above
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        endFlagNext = endFlag;
        halfNext    = oHALF_PERIOD;
        noteOnNext  = oNOTE_ON;
        idxNext     = oNOTE_IDX;
        doneNext    = 1'b0;

        case (state)
            IDLE: begin
                if (iPLAY && !iSTOP) begin
                    stateNext = LOAD;
                    idxNext   = '0;
                end
            end
            LOAD: begin
                endFlagNext = romData[END_BIT];
                halfNext    = pitchHalfPeriod(romPitch);
                noteOnNext  = (romPitch != 4'd0);
                cntNext     = CNT_W'((int'(romData[DUR_MSB:DUR_LSB]) + 1) * UNIT_TICKS);
                stateNext   = NOTE;
            end
            NOTE: begin
                if (cnt == CNT_W'(1)) begin
                    stateNext  = GAP;
                    noteOnNext = 1'b0;
                    cntNext    = CNT_W'(GAP_TICKS);
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(1)) begin
                    cntNext = '0;
                    if (endFlag || oNOTE_IDX == IDX_W'(LAST_IDX)) begin
                        doneNext = 1'b1;
                        idxNext  = '0;
`ifdef MELODY_SEQUENCER_LOOP_EN
                        stateNext = LOAD;
`else
                        stateNext = IDLE;
                        halfNext  = '0;
`endif
                    end else begin
                        stateNext = LOAD;
                        idxNext   = oNOTE_IDX + IDX_W'(1);
                    end
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        // Abort overrides whatever the active state decided
        if (iSTOP && state != IDLE) begin
            stateNext   = IDLE;
            cntNext     = '0;
            endFlagNext = 1'b0;
            halfNext    = '0;
            noteOnNext  = 1'b0;
            idxNext     = '0;
            doneNext    = 1'b0;
        end

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed scoreboard bench for melody_sequencer with UNIT_TICKS=4, GAP_TICKS=2.
module tb_melody_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST, iPLAY, iSTOP;
    logic [15:0] oHALF_PERIOD;
    logic        oNOTE_ON, oBUSY, oDONE;
    logic [3:0]  oNOTE_IDX;

    typedef struct {
        string       tag;
        logic [22:0] value;
    } expect_t;

    expect_t expQ[$];
    int      errors = 0;
    int      checks = 0;

    localparam logic [15:0] HP_E5 = 16'd37922;
    localparam logic [15:0] HP_G5 = 16'd31888;

    melody_sequencer #(
        .UNIT_TICKS (4),
        .GAP_TICKS  (2)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iPLAY        (iPLAY),
        .iSTOP        (iSTOP),
        .oHALF_PERIOD (oHALF_PERIOD),
        .oNOTE_ON     (oNOTE_ON),
        .oBUSY        (oBUSY),
        .oNOTE_IDX    (oNOTE_IDX),
        .oDONE        (oDONE)
    );

    always #5 iCLK = ~iCLK;

    task automatic applyStimulus(input logic play, input logic stop, input logic rst);
        iPLAY = play;
        iSTOP = stop;
        iRST  = rst;
    endtask

    // Expected record layout: {noteOn, halfPeriod, busy, noteIdx, done}
    task automatic pushExp(input string tag, input int n, input logic on, input logic [15:0] half,
                           input logic busy, input logic [3:0] idx, input logic done);
        expect_t e;
        e.tag   = tag;
        e.value = {on, half, busy, idx, done};
        repeat (n) expQ.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t     e;
        logic [22:0] obs;
        @(posedge iCLK);
        #1;
        obs = {oNOTE_ON, oHALF_PERIOD, oBUSY, oNOTE_IDX, oDONE};
        checks++;
        assert (expQ.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboardEmpty observed=%h expected=queued entry", obs);
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            assert (obs === e.value) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) checkOutput();
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        pushExp("reset", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("idle", 2, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(2);

        // Full melody: tone, rest, END tone
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("load0", 1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("note0", 8, 1'b1, HP_E5, 1'b1, 4'd0, 1'b0);
        pushExp("gap0", 2, 1'b0, HP_E5, 1'b1, 4'd0, 1'b0);
        pushExp("load1", 1, 1'b0, HP_E5, 1'b1, 4'd1, 1'b0);
        pushExp("rest1", 12, 1'b0, 16'd0, 1'b1, 4'd1, 1'b0);
        pushExp("gap1", 2, 1'b0, 16'd0, 1'b1, 4'd1, 1'b0);
        pushExp("load2", 1, 1'b0, 16'd0, 1'b1, 4'd2, 1'b0);
        pushExp("note2", 4, 1'b1, HP_G5, 1'b1, 4'd2, 1'b0);
        pushExp("gap2", 2, 1'b0, HP_G5, 1'b1, 4'd2, 1'b0);
`ifdef MELODY_SEQUENCER_LOOP_EN
        pushExp("loopDone", 1, 1'b0, HP_G5, 1'b1, 4'd0, 1'b1);
        pushExp("loopNote", 1, 1'b1, HP_E5, 1'b1, 4'd0, 1'b0);
        runCycles(34);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("loopStop", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
`else
        pushExp("done", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b1);
        pushExp("idleAfterDone", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(34);
`endif

        // Stop mid-note, then simultaneous play+stop is ignored
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("stopLoad", 1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("stopNote", 2, 1'b1, HP_E5, 1'b1, 4'd0, 1'b0);
        runCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("stopIdle", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pushExp("playStopIgnored", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("idleHold", 2, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(2);

        // Reset mid-gap beats a concurrent play, then play restarts at entry 0
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("rstLoad", 1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("rstNote", 8, 1'b1, HP_E5, 1'b1, 4'd0, 1'b0);
        pushExp("rstGap", 1, 1'b0, HP_E5, 1'b1, 4'd0, 1'b0);
        runCycles(9);
        applyStimulus(1'b1, 1'b1, 1'b1);
        pushExp("resetMidGap", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("restartLoad", 1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("restartNote", 2, 1'b1, HP_E5, 1'b1, 4'd0, 1'b0);
        runCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("finalStop", 1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboardDrain observed=%0d expected=0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter UNIT_TICKS, default 1_500_000, clock cycles per note-duration unit.
REQ-002 Parameter GAP_TICKS, default 300_000, silent clock cycles inserted after every note.
REQ-003 Parameter LAST_IDX, default 15, index of the last ROM entry played.
REQ-004 iCLK  input  1  single system clock, all logic on its rising edge.
REQ-005 iRST  input  1  reset; synchronous and active-high.
REQ-006 iPLAY  input  1  start request, sampled each cycle; ignored while oBUSY=1.
REQ-007 iSTOP  input  1  abort request, sampled each cycle.
REQ-008 oHALF_PERIOD  output  16  half-period (in iCLK cycles) of the current tone, consumed by the downstream square-wave generator.
REQ-009 oNOTE_ON  output  1  1 = downstream generator shall sound oHALF_PERIOD; 0 = silence.
REQ-010 oBUSY  output  1  1 while any state other than IDLE is active.
REQ-011 oNOTE_IDX  output  4  ROM index of the entry being played.
REQ-012 oDONE  output  1  one-cycle pulse on melody completion.

Function
REQ-013 ROM entry, 8 bits: [7] END flag, [6:4] DUR, [3:0] PITCH; PITCH 0 = rest, 1..15 index the package pitch table giving the 16-bit half-period.
REQ-014 FSM states: IDLE, LOAD, NOTE, GAP; all outputs are registered.
REQ-015 IDLE: iPLAY=1 and iSTOP=0 -> LOAD with oNOTE_IDX=0.
REQ-016 LOAD: exactly one cycle; latches ROM[oNOTE_IDX], sets oHALF_PERIOD from the table (0 for a rest), loads the duration counter with (DUR+1)*UNIT_TICKS, then -> NOTE.
REQ-017 NOTE: oNOTE_ON=1 (0 for a rest) for exactly (DUR+1)*UNIT_TICKS cycles, then -> GAP.
REQ-018 GAP: oNOTE_ON=0 for exactly GAP_TICKS cycles; oHALF_PERIOD holds its value; then -> LOAD with index+1, or end-of-melody if END=1 or index=LAST_IDX.
REQ-019 End-of-melody: oDONE=1 for one cycle and -> IDLE.
REQ-020 Latency: iPLAY sampled at edge k gives LOAD during cycle k+1 and oNOTE_ON=1 from edge k+2.
REQ-021 iSTOP=1 in any non-IDLE state: next cycle IDLE, oNOTE_ON=0, oHALF_PERIOD=0, oNOTE_IDX=0, oDONE stays 0.
REQ-022 iSTOP and iPLAY both 1 in the same cycle: iSTOP wins; IDLE is held.
REQ-023 Duration counter width covers 8*UNIT_TICKS with no overflow; the index never exceeds LAST_IDX.

Reset
REQ-024 iRST=1 at a clock edge forces IDLE, oHALF_PERIOD=0, oNOTE_ON=0, oBUSY=0, oNOTE_IDX=0, oDONE=0, and clears all counters, including mid-note.
REQ-025 iRST has priority over iSTOP and iPLAY.

Configuration
REQ-026 Macro MELODY_SEQUENCER_LOOP_EN defined: end-of-melody pulses oDONE, then -> LOAD with index 0, looping until iSTOP or iRST.
REQ-027 Macro undefined: end-of-melody -> IDLE per REQ-019.

Structure
REQ-028 Package melody_pkg holds: the state enum, the ROM entry field positions, the 15-entry pitch half-period table, and the constants for the 4-bit index and 16-bit period widths.
REQ-029 One sub-module, melody_rom: a combinational 16x8 ROM with input idx[3:0] and output data[7:0], instantiated once.

Verification
Bench parameters: UNIT_TICKS=4, GAP_TICKS=2; ROM = {0x13, 0x20, 0x85, ...}.
REQ-030 iPLAY pulse at cycle 0 -> LOAD at cycle 1; oNOTE_ON=1 for cycles 2-9 with oHALF_PERIOD=table[3]; oNOTE_ON=0 for cycles 10-11.
REQ-031 Rest entry 0x20 -> oNOTE_ON=0 and oHALF_PERIOD=0 for 12 cycles, then GAP.
REQ-032 END entry 0x85 played -> 4 cycles of tone, then GAP, then oDONE=1 for one cycle and oBUSY=0.
REQ-033 iSTOP mid-NOTE, then iPLAY+iSTOP together -> IDLE next cycle with all outputs 0; simultaneous request ignored.
REQ-034 iRST mid-GAP -> all outputs 0 next cycle; a following iPLAY restarts at index 0.
REQ-035 MELODY_SEQUENCER_LOOP_EN defined -> after END, oDONE pulses, oNOTE_IDX=0, and oBUSY stays 1.
